fmc_adc_lane_deframer: RTL

- Receive-side counterpart of the FMC ADC serial output model. It sits directly after the IDDR/ISERDES capture of the ADC DCO/FR/OUTA/OUTB pairs and ahead of the acquisition core's sample FIFO.
- It consumes one captured bit-pair per lane per clock cycle, aligns to the frame (FR) pattern, and reassembles four signed 14-bit samples per frame.
- It reports alignment lock and counts frame pattern errors.

---
 rtl/fmc_adc_lane_deframer.sv | 129 ++++++++++++
 1 files changed

// File: rtl/fmc_adc_lane_deframer.sv
// rtl/fmc_adc_lane_deframer.sv - FR-aligned deframer for four 14-bit ADC lanes captured as bit-pairs
module fmc_adc_lane_deframer #(
  parameter int g_LOCK_FRAMES = 4,
  parameter int g_MAX_ERRORS  = 3
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic [3:0]  lane_odd_i,
  input  logic [3:0]  lane_even_i,
  input  logic        frame_i,
  input  logic        err_clr_i,
  output logic [63:0] sample_o,
  output logic        sample_valid_o,
  output logic        locked_o,
  output logic [15:0] err_cnt_o
);

  typedef enum logic [1:0] {ST_HUNT, ST_CHECK, ST_LOCKED} state_t;

  localparam logic [7:0] LP_LOCK = 8'(g_LOCK_FRAMES);
  localparam logic [7:0] LP_MAXE = 8'(g_MAX_ERRORS);

  state_t      r_state, w_state_nxt;
  logic [2:0]  r_slot;
  logic        r_frame_prev;
  logic        r_mismatch;
  logic [7:0]  r_good, r_bad;
  logic [13:0] r_shift [4];
  logic [63:0] r_sample;
  logic        r_valid, r_locked;
  logic [15:0] r_err_cnt;

  logic       w_align, w_slot_last, w_fr_exp, w_frame_bad;
  logic       w_err_inc, w_emit;
  logic [7:0] w_good_nxt, w_bad_nxt;

  assign w_align     = (r_state == ST_HUNT) && frame_i && !r_frame_prev;
  assign w_slot_last = (r_state != ST_HUNT) && (r_slot == 3'd7);
  assign w_fr_exp    = ~r_slot[2];
  // A mismatch anywhere in the frame, including slot 7 itself, condemns the frame.
  assign w_frame_bad = r_mismatch | (frame_i != w_fr_exp);
  assign w_good_nxt  = r_good + 8'd1;
  assign w_bad_nxt   = r_bad + 8'd1;

  always_comb begin
    w_state_nxt = r_state;
    w_err_inc   = 1'b0;
    w_emit      = 1'b0;
    case (r_state)
      ST_HUNT: begin
        if (w_align) w_state_nxt = ST_CHECK;
      end
      ST_CHECK: begin
        if (w_slot_last) begin
          if (w_frame_bad) begin
            w_err_inc   = 1'b1;
            w_state_nxt = ST_HUNT;
          end else if (w_good_nxt == LP_LOCK) begin
            w_state_nxt = ST_LOCKED;
          end
        end
      end
      ST_LOCKED: begin
        if (w_slot_last) begin
          if (w_frame_bad) begin
            w_err_inc = 1'b1;
            if (w_bad_nxt == LP_MAXE) w_state_nxt = ST_HUNT;
          end else begin
            w_emit = 1'b1;
          end
        end
      end
      default: w_state_nxt = ST_HUNT;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_state      <= ST_HUNT;
      r_slot       <= 3'd0;
      r_frame_prev <= 1'b0;
      r_mismatch   <= 1'b0;
      r_good       <= 8'd0;
      r_bad        <= 8'd0;
      for (int n = 0; n < 4; n++) r_shift[n] <= 14'd0;
      r_sample     <= 64'd0;
      r_valid      <= 1'b0;
      r_locked     <= 1'b0;
      r_err_cnt    <= 16'd0;
    end else begin
      r_state      <= w_state_nxt;
      r_frame_prev <= frame_i;
      r_locked     <= (r_state == ST_LOCKED);
      r_valid      <= w_emit;

      // Slot counter parks at 0 while hunting; the aligning cycle is slot 0.
      if (r_state == ST_HUNT) r_slot <= w_align ? 3'd1 : 3'd0;
      else                    r_slot <= r_slot + 3'd1;

      if ((r_state == ST_HUNT) || (r_slot == 3'd7)) r_mismatch <= 1'b0;
      else r_mismatch <= r_mismatch | (frame_i != w_fr_exp);

      if (r_state == ST_HUNT) r_good <= 8'd0;
      else if ((r_state == ST_CHECK) && w_slot_last && !w_frame_bad) r_good <= w_good_nxt;

      if (r_state != ST_LOCKED) r_bad <= 8'd0;
      else if (w_slot_last)     r_bad <= w_frame_bad ? w_bad_nxt : 8'd0;

      if (r_slot != 3'd7) begin
        for (int n = 0; n < 4; n++)
          r_shift[n] <= {r_shift[n][11:0], lane_odd_i[n], lane_even_i[n]};
      end

      if (w_emit) begin
        for (int n = 0; n < 4; n++)
          r_sample[16*n +: 16] <= {{2{r_shift[n][13]}}, r_shift[n]};
      end

      if (err_clr_i)                          r_err_cnt <= 16'd0;
      else if (w_err_inc && ~&r_err_cnt)      r_err_cnt <= r_err_cnt + 16'd1;
    end
  end

  assign sample_o       = r_sample;
  assign sample_valid_o = r_valid;
  assign locked_o       = r_locked;
  assign err_cnt_o      = r_err_cnt;

endmodule
